// File: rtl/vc16_pkg.sv
// Shared types and constants for the vc16 execute-stage multiply/divide unit.
package vc16_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } muldiv_state_t;

   localparam logic MD_MUL = 1'b0;
   localparam logic MD_DIV = 1'b1;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of either the shift-add multiply or the restoring divide.
// For multiply acc/aq/b are accumulator, shifted multiplicand and shifted multiplier;
// for divide acc/aq are the partial remainder and the quotient register, b the divisor.
module muldiv_step
   import vc16_pkg::*;
#(
   parameter int RV = 32
) (
   input  logic          op,
   input  logic [RV-1:0] acc,
   input  logic [RV-1:0] aq,
   input  logic [RV-1:0] b,
   output logic [RV-1:0] acc_next,
   output logic [RV-1:0] aq_next,
   output logic [RV-1:0] b_next
);

   logic [RV:0] r_wide;
   logic        r_ge;

   // Compute the next acc/aq/b for a single step; the remainder compare uses one extra bit
   // because the shifted remainder can exceed RV bits when the divisor is large.
   always_comb begin
      acc_next = acc;
      aq_next  = aq;
      b_next   = b;
      r_wide   = {acc, aq[RV-1]};
      r_ge     = (r_wide >= {1'b0, b});
      if (op == MD_MUL) begin
         acc_next = b[0] ? (acc + aq) : acc;
         aq_next  = {aq[RV-2:0], 1'b0};
         b_next   = {1'b0, b[RV-1:1]};
      end else begin
         acc_next = r_ge ? (r_wide[RV-1:0] - b) : r_wide[RV-1:0];
         aq_next  = {aq[RV-2:0], r_ge};
      end
   end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer: IDLE/RUN/DONE FSM, step counter and operand registers
// around a single shared muldiv_step iteration.
module muldiv_seq
   import vc16_pkg::*;
#(
   parameter int RV = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          is_div,
   input  logic [RV-1:0] a,
   input  logic [RV-1:0] b,
   input  logic          kill,
   output logic          busy,
   output logic          done,
   output logic [RV-1:0] result,
   output logic [RV-1:0] rem
);

   localparam int CW = $clog2(RV) + 1;

   muldiv_state_t state, state_next;
   logic          op_reg;
   logic [RV-1:0] acc_reg, aq_reg, b_reg;
   logic [RV-1:0] acc_next, aq_next, b_next;
   logic [CW-1:0] count;
   logic          accept, div_zero, last_step;

   muldiv_step #(.RV(RV)) u_step (
      .op       (op_reg),
      .acc      (acc_reg),
      .aq       (aq_reg),
      .b        (b_reg),
      .acc_next (acc_next),
      .aq_next  (aq_next),
      .b_next   (b_next)
   );

   assign busy = (state == RUN);
   assign done = (state == DONE);

   // Next-state logic: kill always wins, start is only taken outside RUN, divide by zero skips RUN.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      div_zero   = 1'b0;
      last_step  = ((op_reg == MD_MUL) && (b_next == '0)) || (count == CW'(RV - 1));
      case (state)
         IDLE, DONE: begin
            state_next = IDLE;
            if (!kill && start) begin
               accept = 1'b1;
               if ((is_div == MD_DIV) && (b == '0)) begin
                  div_zero   = 1'b1;
                  state_next = DONE;
               end else begin
                  state_next = RUN;
               end
            end
         end
         RUN: begin
            if (kill) begin
               state_next = IDLE;
            end else if (last_step) begin
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Operand latch on accept, one iteration per RUN cycle, and result capture on the final step.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_reg  <= MD_MUL;
         acc_reg <= '0;
         aq_reg  <= '0;
         b_reg   <= '0;
         count   <= '0;
         result  <= '0;
         rem     <= '0;
      end else if (accept) begin
         op_reg  <= is_div;
         acc_reg <= '0;
         aq_reg  <= a;
         b_reg   <= b;
         count   <= '0;
         if (div_zero) begin
            result <= '1;
            rem    <= a;
         end
      end else if ((state == RUN) && !kill) begin
         acc_reg <= acc_next;
         aq_reg  <= aq_next;
         b_reg   <= b_next;
         count   <= count + 1'b1;
         if (last_step) begin
            result <= (op_reg == MD_DIV) ? aq_next : acc_next;
            rem    <= (op_reg == MD_DIV) ? acc_next : '0;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: an arithmetic reference model checked every cycle,
// plus directed operations with hand-computed results.
module tb_muldiv_seq;

   localparam int RV = 32;

   logic          clk = 1'b0;
   logic          reset, start, is_div, kill;
   logic [RV-1:0] a, b;
   logic          busy, done;
   logic [RV-1:0] result, rem;

   int n_compared   = 0;
   int n_mismatched = 0;
   bit check_en     = 1'b0;

   bit            m_busy = 1'b0;
   bit            m_done = 1'b0;
   logic [RV-1:0] m_res  = '0;
   logic [RV-1:0] m_rem  = '0;
   logic [RV-1:0] p_res  = '0;
   logic [RV-1:0] p_rem  = '0;
   logic [63:0]   prod;
   int            m_left = 0;

   muldiv_seq #(.RV(RV)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .is_div (is_div),
      .a      (a),
      .b      (b),
      .kill   (kill),
      .busy   (busy),
      .done   (done),
      .result (result),
      .rem    (rem)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [RV-1:0] actual,
                              input logic [RV-1:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Multiply step count: one per multiplier bit up to its highest set bit, minimum one.
   function automatic int mulSteps(input logic [RV-1:0] bv);
      int s = 1;
      for (int i = 0; i < RV; i++) begin
         if (bv[i]) s = i + 1;
      end
      return s;
   endfunction

   // Reference model: result from plain arithmetic, remaining cycles from the op's step count.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_busy = 1'b0; m_done = 1'b0; m_left = 0;
         m_res  = '0;   m_rem  = '0;
      end else if (kill) begin
         m_busy = 1'b0; m_done = 1'b0; m_left = 0;
      end else if (m_busy) begin
         m_left--;
         if (m_left == 0) begin
            m_busy = 1'b0; m_done = 1'b1;
            m_res  = p_res; m_rem = p_rem;
         end
      end else begin
         m_done = 1'b0;
         if (start) begin
            if (is_div && (b == '0)) begin
               m_done = 1'b1; m_res = '1; m_rem = a;
            end else if (is_div) begin
               m_busy = 1'b1; m_left = RV;
               p_res  = a / b; p_rem = a % b;
            end else begin
               prod   = {32'd0, a} * {32'd0, b};
               m_busy = 1'b1; m_left = mulSteps(b);
               p_res  = prod[RV-1:0]; p_rem = '0;
            end
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (check_en && reset) begin
         checkOutput("cyc_busy",   RV'(busy), RV'(m_busy));
         checkOutput("cyc_done",   RV'(done), RV'(m_done));
         checkOutput("cyc_result", result,    m_res);
         checkOutput("cyc_rem",    rem,       m_rem);
      end
   end

   task automatic waitDone(output int busy_cycles, output bit got);
      busy_cycles = 0;
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         if (done) got = 1'b1;
         else begin
            if (busy) busy_cycles++;
            @(negedge clk);
         end
      end
   endtask

   // Drives one start at the current negedge, then waits (bounded) for done.
   task automatic applyStimulus(input logic div, input logic [RV-1:0] av, input logic [RV-1:0] bv,
                                output int busy_cycles, output logic [RV-1:0] res,
                                output logic [RV-1:0] rm, output bit got);
      start = 1'b1; is_div = div; a = av; b = bv;
      @(negedge clk);
      start = 1'b0;
      waitDone(busy_cycles, got);
      res = result;
      rm  = rem;
   endtask

   task automatic runAndCheck(input string name, input logic div, input logic [RV-1:0] av,
                              input logic [RV-1:0] bv, input int exp_busy,
                              input logic [RV-1:0] exp_res, input logic [RV-1:0] exp_rem);
      int            bc;
      logic [RV-1:0] r, m;
      bit            got;
      applyStimulus(div, av, bv, bc, r, m, got);
      checkOutput({name, "_done_seen"}, RV'(got), RV'(1));
      checkOutput({name, "_busy_cycles"}, RV'(bc), RV'(exp_busy));
      checkOutput({name, "_result"}, r, exp_res);
      checkOutput({name, "_rem"}, m, exp_rem);
   endtask

   initial begin
      int bc;
      bit got;
      int done_seen;

      reset = 1'b1; start = 1'b0; is_div = 1'b0; kill = 1'b0; a = '0; b = '0;
      #1 reset = 1'b0;
      #2;
      checkOutput("reset_busy",   RV'(busy), '0);
      checkOutput("reset_done",   RV'(done), '0);
      checkOutput("reset_result", result,    '0);
      checkOutput("reset_rem",    rem,       '0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      check_en = 1'b1;
      @(negedge clk);

      runAndCheck("mul_7x6", 1'b0, 32'd7, 32'd6, 3, 32'd42, 32'd0);
      @(negedge clk);
      runAndCheck("mul_9x0", 1'b0, 32'd9, 32'd0, 1, 32'd0, 32'd0);
      @(negedge clk);
      runAndCheck("mul_ones", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, 32'd1, 32'd0);
      @(negedge clk);
      runAndCheck("mul_2p16", 1'b0, 32'h00010000, 32'h00010000, 17, 32'd0, 32'd0);
      @(negedge clk);
      runAndCheck("div_100_7", 1'b1, 32'd100, 32'd7, 32, 32'd14, 32'd2);
      @(negedge clk);
      runAndCheck("div_max_1", 1'b1, 32'hFFFFFFFF, 32'd1, 32, 32'hFFFFFFFF, 32'd0);
      @(negedge clk);
      runAndCheck("div_5_0", 1'b1, 32'd5, 32'd0, 0, 32'hFFFFFFFF, 32'd5);
      @(negedge clk);

      // Kill a divide on its tenth step.
      start = 1'b1; is_div = 1'b1; a = 32'd1000; b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      checkOutput("kill_busy",   RV'(busy), '0);
      checkOutput("kill_done",   RV'(done), '0);
      checkOutput("kill_result", result,    32'hFFFFFFFF);
      checkOutput("kill_rem",    rem,       32'd5);
      done_seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      checkOutput("kill_no_done", RV'(done_seen), '0);
      runAndCheck("mul_3x3", 1'b0, 32'd3, 32'd3, 2, 32'd9, 32'd0);
      @(negedge clk);

      // Kill together with start in IDLE launches nothing.
      start = 1'b1; kill = 1'b1; is_div = 1'b0; a = 32'd4; b = 32'd4;
      @(negedge clk);
      start = 1'b0; kill = 1'b0;
      done_seen = 0;
      repeat (5) begin
         if (busy || done) done_seen++;
         @(negedge clk);
      end
      checkOutput("killstart_idle", RV'(done_seen), '0);
      checkOutput("killstart_result", result, 32'd9);

      // Start while busy is ignored.
      start = 1'b1; is_div = 1'b0; a = 32'd7; b = 32'd6;
      @(negedge clk);
      is_div = 1'b1; a = 32'd100; b = 32'd7;
      @(negedge clk);
      start = 1'b0;
      waitDone(bc, got);
      checkOutput("ignbusy_done_seen", RV'(got), RV'(1));
      checkOutput("ignbusy_result", result, 32'd42);
      @(negedge clk);
      checkOutput("ignbusy_after", RV'(busy), '0);

      // Start in the DONE cycle runs immediately.
      runAndCheck("b2b_first", 1'b0, 32'd7, 32'd6, 3, 32'd42, 32'd0);
      runAndCheck("b2b_second", 1'b0, 32'd3, 32'd3, 2, 32'd9, 32'd0);
      @(negedge clk);

      // Asynchronous reset in the middle of a divide.
      start = 1'b1; is_div = 1'b1; a = 32'd100; b = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      #3 reset = 1'b0;
      #1;
      checkOutput("areset_busy",   RV'(busy), '0);
      checkOutput("areset_done",   RV'(done), '0);
      checkOutput("areset_result", result,    '0);
      checkOutput("areset_rem",    rem,       '0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      runAndCheck("post_reset_mul", 1'b0, 32'd12, 32'd11, 4, 32'd132, 32'd0);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
